// File: rtl/elem_seq.sv
// ---------------------------------------------------------------------------------------------
// elem_seq -- envelope element sequencer
//
// Plays one pulse per accepted command. A pulse walks the envelope memory from envstart for
// envlength consecutive addresses (wrapping modulo 2^ENV_ADDR_WIDTH). While a pulse plays,
// the command parameters are presented on registered outputs. After the last sample the
// sequencer either goes idle or, for CW commands (mode[0]=1), holds the last address until
// the next command arrives.
//
// Optional feature (compile-time macro ELEM_SEQ_PENDING_EN):
//   defined   - a one-deep pending register accepts one command during a pulse and starts
//               it on the cycle after the current pulse_end (gapless).
//   undefined - no pending register; every command arriving during a pulse is dropped.
//
// Ports:
//   clk          in   clock, everything on the rising edge
//   reset        in   synchronous active-high reset (overrides a concurrent cmdstb)
//   cmdstb       in   one-cycle command strobe; parameter inputs sampled only when high
//   envstart     in   first envelope address
//   envlength    in   envelope sample count (0 = no-op command)
//   ampx, ampy   in   amplitude parameters
//   freqaddr     in   frequency table address
//   pini         in   initial phase
//   mode         in   mode[0]=1 selects CW hold after the pulse; mode[1] is passed through
//   env_addr     out  envelope read address
//   env_valid    out  env_addr is a live read address
//   amp_x/amp_y/freq_out/phase_out/mode_out
//                out  registered parameters of the active command
//   pulse_start  out  high on the first sample of a pulse
//   pulse_end    out  high on the last sample of a pulse
//   busy         out  pulse playing or pending command waiting
//   drop_cnt     out  saturating count of rejected commands
// ---------------------------------------------------------------------------------------------

module elem_seq #(
    parameter int unsigned ENV_ADDR_WIDTH  = 12,
    parameter int unsigned AMP_WIDTH       = 16,
    parameter int unsigned FREQ_ADDR_WIDTH = 9,
    parameter int unsigned PHASE_WIDTH     = 17,
    parameter int unsigned MODE_WIDTH      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmdstb,
    input  logic [ENV_ADDR_WIDTH-1:0]  envstart,
    input  logic [ENV_ADDR_WIDTH-1:0]  envlength,
    input  logic [AMP_WIDTH-1:0]       ampx,
    input  logic [AMP_WIDTH-1:0]       ampy,
    input  logic [FREQ_ADDR_WIDTH-1:0] freqaddr,
    input  logic [PHASE_WIDTH-1:0]     pini,
    input  logic [MODE_WIDTH-1:0]      mode,
    output logic [ENV_ADDR_WIDTH-1:0]  env_addr,
    output logic                       env_valid,
    output logic [AMP_WIDTH-1:0]       amp_x,
    output logic [AMP_WIDTH-1:0]       amp_y,
    output logic [FREQ_ADDR_WIDTH-1:0] freq_out,
    output logic [PHASE_WIDTH-1:0]     phase_out,
    output logic [MODE_WIDTH-1:0]      mode_out,
    output logic                       pulse_start,
    output logic                       pulse_end,
    output logic                       busy,
    output logic [7:0]                 drop_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StHold = 2'd2
    } state_e;

    typedef struct packed {
        logic [ENV_ADDR_WIDTH-1:0]  start;
        logic [ENV_ADDR_WIDTH-1:0]  len;
        logic [AMP_WIDTH-1:0]       ampx;
        logic [AMP_WIDTH-1:0]       ampy;
        logic [FREQ_ADDR_WIDTH-1:0] freq;
        logic [PHASE_WIDTH-1:0]     phase;
        logic [MODE_WIDTH-1:0]      mode;
    } cmd_t;

    localparam logic [ENV_ADDR_WIDTH-1:0] LenOne = ENV_ADDR_WIDTH'(1);

    state_e                    state_q;
    // Samples still to play after the current one; zero marks the last sample.
    logic [ENV_ADDR_WIDTH-1:0] remain_q;

    cmd_t cmd_in;
    cmd_t src;
    logic cmd_valid;
    logic in_play;
    logic last_sample;
    logic start;
    logic drop;
    logic pend_busy;

`ifdef ELEM_SEQ_PENDING_EN
    cmd_t pend_q;
    logic pend_valid_q;
    logic pend_start;
    logic pend_store;
    logic direct_chain;
`endif

    // ---------------------------------------------------------------------------------------
    // Command decode
    // ---------------------------------------------------------------------------------------
    always_comb begin
        cmd_in.start = envstart;
        cmd_in.len   = envlength;
        cmd_in.ampx  = ampx;
        cmd_in.ampy  = ampy;
        cmd_in.freq  = freqaddr;
        cmd_in.phase = pini;
        cmd_in.mode  = mode;

        // Zero-length commands are ignored outright: never started, never counted.
        cmd_valid   = cmdstb && (envlength != '0);
        in_play     = (state_q == StPlay);
        last_sample = in_play && (remain_q == '0);

`ifdef ELEM_SEQ_PENDING_EN
        pend_start   = last_sample && pend_valid_q;
        // A command on the last sample with an empty slot bypasses the slot and chains
        // directly, so it still starts on the very next cycle.
        direct_chain = cmd_valid && last_sample && !pend_valid_q;
        pend_store   = cmd_valid && in_play && !pend_valid_q && !last_sample;
        drop         = cmd_valid && in_play && pend_valid_q;
        start        = (cmd_valid && !in_play) || pend_start || direct_chain;
        src          = pend_start ? pend_q : cmd_in;
        pend_busy    = pend_valid_q;
`else
        drop         = cmd_valid && in_play;
        start        = cmd_valid && !in_play;
        src          = cmd_in;
        pend_busy    = 1'b0;
`endif
    end

    assign busy = in_play || pend_busy;

    // ---------------------------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            remain_q    <= '0;
            env_addr    <= '0;
            env_valid   <= 1'b0;
            pulse_start <= 1'b0;
            pulse_end   <= 1'b0;
            amp_x       <= '0;
            amp_y       <= '0;
            freq_out    <= '0;
            phase_out   <= '0;
            mode_out    <= '0;
            drop_cnt    <= '0;
`ifdef ELEM_SEQ_PENDING_EN
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
`endif
        end else begin
            pulse_start <= 1'b0;
            pulse_end   <= 1'b0;

            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

`ifdef ELEM_SEQ_PENDING_EN
            if (pend_store) begin
                pend_q       <= cmd_in;
                pend_valid_q <= 1'b1;
            end else if (pend_start) begin
                pend_valid_q <= 1'b0;
            end
`endif

            if (start) begin
                state_q     <= StPlay;
                env_addr    <= src.start;
                remain_q    <= src.len - LenOne;
                env_valid   <= 1'b1;
                pulse_start <= 1'b1;
                pulse_end   <= (src.len == LenOne);
                amp_x       <= src.ampx;
                amp_y       <= src.ampy;
                freq_out    <= src.freq;
                phase_out   <= src.phase;
                mode_out    <= src.mode;
            end else begin
                case (state_q)
                    StPlay: begin
                        if (remain_q == '0) begin
                            // mode_out holds the mode of the pulse that just finished.
                            if (mode_out[0]) begin
                                state_q <= StHold;
                            end else begin
                                state_q   <= StIdle;
                                env_valid <= 1'b0;
                            end
                        end else begin
                            env_addr  <= env_addr + LenOne;
                            remain_q  <= remain_q - LenOne;
                            pulse_end <= (remain_q == LenOne);
                        end
                    end
                    default: begin
                        // Idle and hold keep their outputs until a command starts.
                    end
                endcase
            end
        end
    end

endmodule
